gf180mcu_fd_sc_mcu7t5v0__arb_rr: RTL and testbench

- Round-robin arbiter that time-shares a single resource (a cell-level shared net or driver, e.g. a wired-NOR bus or a shared test/scan path) among N requesters inside a 7-track 5V0 macro.
- Issues a registered one-hot grant with break-before-make: one dead cycle between owners.
- Enforces an optional maximum hold time, then force-releases the owner.
- Provides a combinational all-idle flag: the NOR of all requests.

---
 rtl/gf180mcu_fd_sc_mcu7t5v0__arb_rr.sv | 102 ++++++++++
 tb/tb_gf180mcu_fd_sc_mcu7t5v0__arb_rr.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__arb_rr.sv
// gf180mcu_fd_sc_mcu7t5v0__arb_rr: round-robin arbiter with break-before-make gap and hold timeout
//   CLK  : rising-edge clock
//   RN   : asynchronous active-low reset
//   EN   : enables new grants (never preempts the current owner)
//   REQ  : level-sensitive request vector
//   GNT  : registered one-hot-or-zero grant
//   BUSY : registered, high while any GNT bit is set
//   TMO  : registered one-cycle pulse after a forced release
//   IDLE : combinational NOR of REQ
module gf180mcu_fd_sc_mcu7t5v0__arb_rr #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 16
) (
    input  logic         CLK,
    input  logic         RN,
    input  logic         EN,
    input  logic [N-1:0] REQ,
    output logic [N-1:0] GNT,
    output logic         BUSY,
    output logic         TMO,
    output logic         IDLE
);
    localparam int PW = $clog2(N);
    localparam int CW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

    typedef enum logic [1:0] {S_IDLE, S_GAP, S_OWN} state_t;

    state_t          r_state, w_state_n;
    logic [N-1:0]    r_gnt, w_gnt_n;
    logic            r_busy, r_tmo, w_tmo_n;
    logic [PW-1:0]   r_ptr, w_ptr_n;
    logic [CW-1:0]   r_cnt, w_cnt_n;
    logic [PW-1:0]   w_sel, w_own, w_idx;
    logic            w_last;

    // scan from the far end so the requester closest to r_ptr wins
    always_comb begin
        w_sel = '0;
        w_idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            w_idx = PW'((int'(r_ptr) + k) % N);
            if (REQ[w_idx]) w_sel = w_idx;
        end
    end

    always_comb begin
        w_own = '0;
        for (int i = 0; i < N; i++) if (r_gnt[i]) w_own = PW'(i);
    end

    assign w_last = (MAX_HOLD != 0) && (r_cnt == CW'(MAX_HOLD - 1));

    always_comb begin
        w_state_n = r_state;
        w_gnt_n   = r_gnt;
        w_tmo_n   = 1'b0;
        w_ptr_n   = r_ptr;
        w_cnt_n   = r_cnt;
        if (r_state == S_OWN) begin
            // a falling request wins over a coincident timeout, so TMO only flags true overstays
            if (!REQ[w_own] || w_last) begin
                w_gnt_n   = '0;
                w_tmo_n   = REQ[w_own];
                w_ptr_n   = (w_own == PW'(N - 1)) ? '0 : w_own + 1'b1;
                w_state_n = S_GAP;
            end else begin
                w_cnt_n = r_cnt + 1'b1;
            end
        end else if (EN && |REQ) begin
            w_gnt_n   = {{(N-1){1'b0}}, 1'b1} << w_sel;
            w_cnt_n   = '0;
            w_state_n = S_OWN;
        end else begin
            w_gnt_n   = '0;
            w_state_n = S_IDLE;
        end
    end

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            r_state <= S_IDLE;
            r_gnt   <= '0;
            r_busy  <= 1'b0;
            r_tmo   <= 1'b0;
            r_ptr   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_n;
            r_gnt   <= w_gnt_n;
            r_busy  <= |w_gnt_n;
            r_tmo   <= w_tmo_n;
            r_ptr   <= w_ptr_n;
            r_cnt   <= w_cnt_n;
        end
    end

    assign GNT  = r_gnt;
    assign BUSY = r_busy;
    assign TMO  = r_tmo;
    assign IDLE = ~|REQ;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__arb_rr.sv
// tb_gf180mcu_fd_sc_mcu7t5v0__arb_rr: directed and random checks of the round-robin arbiter
module tb_gf180mcu_fd_sc_mcu7t5v0__arb_rr;
    logic       CLK = 1'b0;
    logic       RN;
    logic       EN;
    logic [3:0] REQ;
    logic [3:0] GNT;
    logic       BUSY, TMO, IDLE;
    int         n_vec = 0;
    int         n_err = 0;
    logic [3:0] r_prev = '0;

    gf180mcu_fd_sc_mcu7t5v0__arb_rr #(.N(4), .MAX_HOLD(16)) dut (
        .CLK(CLK), .RN(RN), .EN(EN), .REQ(REQ),
        .GNT(GNT), .BUSY(BUSY), .TMO(TMO), .IDLE(IDLE)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // invariants: one-hot, BUSY mirrors GNT, no owner-to-owner handover without a gap
    always @(negedge CLK) begin
        if (RN) begin
            chk("onehot", 32'($onehot0(GNT)), 32'd1);
            chk("busy_eq", 32'(BUSY), 32'(|GNT));
            chk("idle_nor", 32'(IDLE), 32'(~|REQ));
            if (r_prev != 4'b0 && GNT != 4'b0) chk("bbm", 32'(GNT), 32'(r_prev));
            if (TMO) chk("tmo_gnt0", 32'(GNT), 32'd0);
        end
        r_prev = RN ? GNT : 4'b0;
    end

    initial begin
        RN = 1'b0; EN = 1'b1; REQ = 4'b1111;
        tick(); tick();
        chk("rst_gnt", 32'(GNT), 32'd0);
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_tmo", 32'(TMO), 32'd0);
        chk("rst_idle0", 32'(IDLE), 32'd0);
        REQ = 4'b0000; #1;
        chk("rst_idle1", 32'(IDLE), 32'd1);
        RN = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("idle_gnt", 32'(GNT), 32'd0);
        end
        // rotation: each owner holds 3 cycles, drops, re-raises a cycle later
        REQ = 4'b1111;
        for (int o = 0; o < 4; o++) begin
            tick();
            chk("rr_gnt", 32'(GNT), 32'(4'b0001 << o));
            tick(); tick();
            chk("rr_hold", 32'(GNT), 32'(4'b0001 << o));
            REQ[o] = 1'b0;
            tick();
            chk("rr_gap", 32'(GNT), 32'd0);
            REQ[o] = 1'b1;
        end
        tick();
        chk("rr_wrap", 32'(GNT), 32'd1);
        REQ = 4'b0000;
        tick(); tick();
        // timeout of requester 1 (pointer now 1)
        REQ = 4'b0010;
        for (int i = 0; i < 16; i++) begin
            tick();
            chk("to_hold", 32'(GNT), 32'h2);
        end
        tick();
        chk("to_gnt0", 32'(GNT), 32'd0);
        chk("to_tmo1", 32'(TMO), 32'd1);
        tick();
        chk("to_regrant", 32'(GNT), 32'h2);
        chk("to_tmo0", 32'(TMO), 32'd0);
        REQ = 4'b0110;
        for (int i = 0; i < 15; i++) tick();
        chk("to2_hold", 32'(GNT), 32'h2);
        tick();
        chk("to2_tmo", 32'(TMO), 32'd1);
        tick();
        chk("to2_next", 32'(GNT), 32'h4);
        REQ = 4'b0000;
        tick(); tick();
        // EN gating with owner 3 (pointer now 3)
        REQ = 4'b1001;
        tick();
        chk("en_own3", 32'(GNT), 32'h8);
        EN = 1'b0;
        tick();
        chk("en_nopreempt", 32'(GNT), 32'h8);
        REQ = 4'b0001;
        tick();
        chk("en_rel", 32'(GNT), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("en_block", 32'(GNT), 32'd0);
        end
        EN = 1'b1;
        tick();
        chk("en_resume", 32'(GNT), 32'h1);
        REQ = 4'b0000;
        tick(); tick();
        // async reset mid-grant (pointer now 1)
        REQ = 4'b0100;
        tick();
        chk("mr_own2", 32'(GNT), 32'h4);
        for (int i = 0; i < 5; i++) tick();
        #2 RN = 1'b0;
        #1;
        chk("mr_gnt0", 32'(GNT), 32'd0);
        chk("mr_busy0", 32'(BUSY), 32'd0);
        REQ = 4'b0101; RN = 1'b1;
        tick();
        chk("mr_ptr0", 32'(GNT), 32'h1);
        // request falls exactly at the last allowed cycle: voluntary, no TMO
        for (int i = 0; i < 15; i++) tick();
        chk("sim_hold", 32'(GNT), 32'h1);
        REQ = 4'b0100;
        tick();
        chk("sim_gnt0", 32'(GNT), 32'd0);
        chk("sim_tmo0", 32'(TMO), 32'd0);
        tick();
        chk("sim_next", 32'(GNT), 32'h4);
        // random traffic; invariants checked by the monitor
        for (int i = 0; i < 10000; i++) begin
            REQ = 4'($urandom);
            EN = ($urandom_range(0, 7) != 0);
            tick();
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
